// File: rtl/instr_buffer_pkg.sv
// Shared TPU types for the instruction buffer: the instruction word and the default depth.
package pkg_tpu;

  typedef struct packed {
    logic        v;
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instr_t;

  localparam int IBUF_DEPTH = 64;

endpackage

// File: rtl/instr_buffer_if.sv
// Loader and fetch-stage handshake bundle for instr_buffer.
interface instr_buffer_if
  import pkg_tpu::*;
#(
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int WIDTH_CNT = $clog2(DEPTH) + 1
);

  logic                 I_Clr;
  logic                 I_Ld_Valid;
  instr_t               I_Ld_Instr;
  logic                 I_Ld_Last;
  logic                 O_Ld_Full;
  logic                 I_Re_Instr;
  instr_t               O_Instr;
  logic                 O_Empty;
  logic                 O_Term;
  logic [WIDTH_CNT-1:0] O_Count;

  modport master (
    output I_Clr, I_Ld_Valid, I_Ld_Instr, I_Ld_Last, I_Re_Instr,
    input  O_Ld_Full, O_Instr, O_Empty, O_Term, O_Count
  );

  modport slave (
    input  I_Clr, I_Ld_Valid, I_Ld_Instr, I_Ld_Last, I_Re_Instr,
    output O_Ld_Full, O_Instr, O_Empty, O_Term, O_Count
  );

endinterface

// File: rtl/instr_buffer_ram.sv
// ibuf_ram: 1-write/1-read storage array with a registered read port.
// The read register holds its value when no read is requested.
module ibuf_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset so the output word is known right after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_buffer.sv
// Instruction buffer between the program loader and the scalar-unit fetch stage.
// Define IBUF_OVF_DET_EN to add the sticky O_Ovf overflow flag port.
module instr_buffer
  import pkg_tpu::*;
#(
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int WIDTH_CNT = $clog2(DEPTH) + 1
) (
  input  logic clock,
  input  logic reset,
  instr_buffer_if.slave bus
`ifdef IBUF_OVF_DET_EN
  ,
  output logic O_Ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = $bits(instr_t) + 1;

  typedef struct packed {
    logic   last;
    instr_t instr;
  } entry_t;

  logic [AW-1:0]        wp, rp;
  logic [WIDTH_CNT-1:0] count;
  logic                 rd_valid;
  logic                 empty, full;
  logic                 wr_acc, rd_acc;
  entry_t               wr_entry, rd_entry;
  instr_t               out_instr;

  assign empty  = (count == '0);
  assign full   = (count == WIDTH_CNT'(DEPTH));
  assign wr_acc = bus.I_Ld_Valid & ~full  & ~bus.I_Clr;
  assign rd_acc = bus.I_Re_Instr & ~empty & ~bus.I_Clr;

  assign wr_entry.last  = bus.I_Ld_Last;
  assign wr_entry.instr = bus.I_Ld_Instr;

  ibuf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wp),
    .wdata (wr_entry),
    .re    (rd_acc),
    .raddr (rp),
    .rdata (rd_entry)
  );

  // Flush wins over any same-cycle traffic; stored words are left in place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else if (bus.I_Clr) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) rp <= rp + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload holds between deliveries; only the valid bit tracks the read.
  always_comb begin
    out_instr   = rd_entry.instr;
    out_instr.v = rd_valid;
  end

  assign bus.O_Instr   = out_instr;
  assign bus.O_Term    = rd_valid & rd_entry.last;
  assign bus.O_Empty   = empty;
  assign bus.O_Ld_Full = full;
  assign bus.O_Count   = count;

`ifdef IBUF_OVF_DET_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         O_Ovf <= 1'b0;
    else if (bus.I_Clr) O_Ovf <= 1'b0;
    else if (bus.I_Ld_Valid & full) O_Ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Randomized self-checking bench for instr_buffer against a queue-based model of the buffer.
module tb_instr_buffer;
  import pkg_tpu::*;

  localparam int DEPTH     = 64;
  localparam int WIDTH_CNT = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic   last;
    instr_t instr;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  instr_buffer_if #(.DEPTH(DEPTH), .WIDTH_CNT(WIDTH_CNT)) bus ();

`ifdef IBUF_OVF_DET_EN
  logic ovf;
`endif

  instr_buffer #(.DEPTH(DEPTH), .WIDTH_CNT(WIDTH_CNT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef IBUF_OVF_DET_EN
    ,
    .O_Ovf (ovf)
`endif
  );

  entry_t model_q[$];
  instr_t exp_payload;
  logic   exp_v, exp_term, exp_ovf;
  int     checks = 0;
  int     errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    instr_t ex;
    ex   = exp_payload;
    ex.v = exp_v;
    checkOutput("count", 64'(bus.O_Count), 64'(model_q.size()));
    checkOutput("empty", 64'(bus.O_Empty), 64'(model_q.size() == 0));
    checkOutput("full",  64'(bus.O_Ld_Full), 64'(model_q.size() == DEPTH));
    checkOutput("instr", 64'(bus.O_Instr), 64'(ex));
    checkOutput("term",  64'(bus.O_Term), 64'(exp_term));
`ifdef IBUF_OVF_DET_EN
    checkOutput("ovf",   64'(ovf), 64'(exp_ovf));
`endif
  endtask

  function automatic instr_t randInstr();
    instr_t r;
    r.v       = 1'($urandom);
    r.opcode  = 8'($urandom);
    r.operand = 24'($urandom);
    return r;
  endfunction

  function automatic void modelReset();
    model_q.delete();
    exp_payload = '0;
    exp_v       = 1'b0;
    exp_term    = 1'b0;
    exp_ovf     = 1'b0;
  endfunction

  // One clock of traffic: the model steps from its pre-edge state, then outputs are checked.
  task automatic applyStimulus(input logic ld, input instr_t ins, input logic last,
                               input logic re, input logic clr);
    bit     was_full, was_empty;
    entry_t e;
    bus.I_Ld_Valid = ld;
    bus.I_Ld_Instr = ins;
    bus.I_Ld_Last  = last;
    bus.I_Re_Instr = re;
    bus.I_Clr      = clr;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (clr) begin
      model_q.delete();
      exp_v    = 1'b0;
      exp_term = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      if (ld && was_full) exp_ovf = 1'b1;
      if (re && !was_empty) begin
        e           = model_q.pop_front();
        exp_payload = e.instr;
        exp_v       = 1'b1;
        exp_term    = e.last;
      end else begin
        exp_v    = 1'b0;
        exp_term = 1'b0;
      end
      if (ld && !was_full) begin
        e.last  = last;
        e.instr = ins;
        model_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeOne(input logic last);
    applyStimulus(1'b1, randInstr(), last, 1'b0, 1'b0);
  endtask

  task automatic readOne();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.I_Clr      = 1'b0;
    bus.I_Ld_Valid = 1'b0;
    bus.I_Ld_Instr = '0;
    bus.I_Ld_Last  = 1'b0;
    bus.I_Re_Instr = 1'b0;
    modelReset();

    #12;
    checkAll();
    @(negedge clock);
    reset = 1'b1;
    idle();

    $display("[TB] three-instruction program with last tag");
    writeOne(1'b0);
    writeOne(1'b0);
    writeOne(1'b1);
    for (int i = 0; i < 6; i++) readOne();

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < DEPTH; i++) writeOne(1'($urandom));
    writeOne(1'b1);
    applyStimulus(1'b1, randInstr(), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) readOne();

    $display("[TB] simultaneous read and write at count one");
    writeOne(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randInstr(), 1'($urandom), 1'b1, 1'b0);
    readOne();
    readOne();

    $display("[TB] 150 streamed pairs across pointer wrap");
    writeOne(1'b0);
    for (int i = 0; i < 150; i++) applyStimulus(1'b1, randInstr(), 1'($urandom), 1'b1, 1'b0);
    readOne();
    readOne();

    $display("[TB] flush mid-drain");
    for (int i = 0; i < 12; i++) writeOne(1'($urandom));
    readOne();
    readOne();
    applyStimulus(1'b1, randInstr(), 1'b1, 1'b1, 1'b1);
    readOne();
    idle();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 99) < 60), randInstr(), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) == 0));

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 5; i++) writeOne(1'($urandom));
    applyStimulus(1'b1, randInstr(), 1'b1, 1'b1, 1'b0);
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clock);
    reset = 1'b1;
    idle();
    writeOne(1'b1);
    readOne();
    readOne();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
